// File: rtl/equal_block.sv
// Purpose: Nock opcode 5 unit; walks two nouns in lockstep with a pair stack, writes loobean in place.
// Latency: 7 cycles start->finished for equal root atoms on a 1-cycle memory; ~3 cycles + memory wait per popped pair.
// Backpressure: requests issue only while mem_ready=1; each W_* state stalls until mem_ready returns after the strobe.
//
// Ports: clk/rst (sync, active-high); eq_start mux select; module_address = opcode cell from traversal;
// memory side mem_ready/mem_execute/mem_func/address1/address2/read_data1/read_data2/write_data;
// results eq_address/eq_data/finished/eq_return_sys_func/eq_return_state/eq_error. free_addr unused.
module equal_block #(
    parameter logic [2:0] SEL_ID       = 3'd4,
    parameter int         ADDR_W       = 10,
    parameter int         VAL_W        = 10,
    parameter int         TAG_W        = 4,
    parameter int         DATA_W       = TAG_W + 2 * VAL_W,
    parameter int         STACK_DEPTH  = 16,
    parameter logic [3:0] RET_SYS_FUNC = 4'd1,
    parameter logic [3:0] RET_STATE    = 4'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        eq_start,
    input  logic [ADDR_W-1:0] module_address,
    output logic [ADDR_W-1:0] eq_address,
    output logic [DATA_W-1:0] eq_data,
    input  logic              mem_ready,
    output logic              mem_execute,
    output logic [1:0]        mem_func,
    output logic [ADDR_W-1:0] address1,
    output logic [ADDR_W-1:0] address2,
    input  logic [ADDR_W-1:0] free_addr,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] write_data,
    output logic              finished,
    output logic [3:0]        eq_return_sys_func,
    output logic [3:0]        eq_return_state,
    output logic [TAG_W-1:0]  eq_error
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);

    typedef enum logic [3:0] {
        IDLE, RD_ROOT, W_ROOT, CMP, RD_PAIR, W_PAIR, WR, W_WR, DONE, ERR
    } state_t;

    typedef enum logic [1:0] {F_EQ, F_NE, F_PUSH} fres_t;

    state_t            state;
    logic [DATA_W-1:0] wa;          // current left word (root word in root mode)
    logic [DATA_W-1:0] wb;          // current right word
    logic              root_mode;   // wa holds the root cell: compare its hed against its tail
    logic              phase;       // second cycle of a double push (head pair)
    logic              result;      // 0 = equal (yes), 1 = not equal (no)
    logic [SP_W-1:0]   sp;
    logic [ADDR_W-1:0] stk_a [STACK_DEPTH];
    logic [ADDR_W-1:0] stk_b [STACK_DEPTH];

    // Classify one field pair: pointer flag mismatch or differing atoms end the walk,
    // identical pointers are trivially equal, differing pointers need a deeper look.
    function automatic fres_t classify(input logic pa, input logic [VAL_W-1:0] va,
                                       input logic pb, input logic [VAL_W-1:0] vb);
        if (pa != pb)     return F_NE;
        else if (va == vb) return F_EQ;
        else if (pa)      return F_PUSH;
        else              return F_NE;
    endfunction

    fres_t             h_res, t_res;
    logic [ADDR_W-1:0] h_a, h_b, t_a, t_b;
    logic              any_ne, need_h, need_t, stack_full;
    logic [IDX_W-1:0]  push_idx, top_idx;
    logic [DATA_W-1:0] wr_word;

    always_comb begin
        h_res = F_EQ;
        t_res = F_EQ;
        h_a   = ADDR_W'(wa[2*VAL_W-1 -: VAL_W]);
        h_b   = ADDR_W'(wb[2*VAL_W-1 -: VAL_W]);
        t_a   = ADDR_W'(wa[VAL_W-1:0]);
        t_b   = ADDR_W'(wb[VAL_W-1:0]);
        if (root_mode) begin
            // The root cell's own hed and tail are the first pair.
            h_res = classify(wa[DATA_W-TAG_W+1], wa[2*VAL_W-1 -: VAL_W],
                             wa[DATA_W-TAG_W],   wa[VAL_W-1:0]);
            h_b   = ADDR_W'(wa[VAL_W-1:0]);
        end else begin
            h_res = classify(wa[DATA_W-TAG_W+1], wa[2*VAL_W-1 -: VAL_W],
                             wb[DATA_W-TAG_W+1], wb[2*VAL_W-1 -: VAL_W]);
            t_res = classify(wa[DATA_W-TAG_W],   wa[VAL_W-1:0],
                             wb[DATA_W-TAG_W],   wb[VAL_W-1:0]);
        end
        any_ne     = (h_res == F_NE) || (t_res == F_NE);
        need_h     = (h_res == F_PUSH);
        need_t     = (t_res == F_PUSH);
        stack_full = (sp == SP_W'(STACK_DEPTH));
        push_idx   = IDX_W'(sp);
        top_idx    = IDX_W'(sp - 1'b1);
        wr_word    = {{TAG_W{1'b0}}, {{(VAL_W-1){1'b0}}, result}, {VAL_W{1'b0}}};
    end

    logic unused_bits;
    assign unused_bits = ^{free_addr, wa[DATA_W-1:DATA_W-TAG_W+2], wb[DATA_W-1:DATA_W-TAG_W+2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            wa                 <= '0;
            wb                 <= '0;
            root_mode          <= 1'b0;
            phase              <= 1'b0;
            result             <= 1'b0;
            sp                 <= '0;
            eq_address         <= '0;
            eq_data            <= '0;
            mem_execute        <= 1'b0;
            mem_func           <= 2'b00;
            address1           <= '0;
            address2           <= '0;
            write_data         <= '0;
            finished           <= 1'b0;
            eq_return_sys_func <= 4'd0;
            eq_return_state    <= 4'd0;
            eq_error           <= '0;
        end else begin
            mem_execute <= 1'b0;
            finished    <= 1'b0;
            case (state)
                IDLE: begin
                    if (eq_start == SEL_ID) begin
                        eq_address         <= module_address;
                        sp                 <= '0;
                        eq_error           <= '0;
                        eq_return_sys_func <= 4'd0;
                        eq_return_state    <= 4'd0;
                        state              <= RD_ROOT;
                    end
                end
                RD_ROOT: begin
                    if (mem_ready) begin
                        address1    <= eq_address;
                        address2    <= eq_address;
                        mem_func    <= 2'b00;
                        mem_execute <= 1'b1;
                        state       <= W_ROOT;
                    end
                end
                W_ROOT, W_PAIR: begin
                    // mem_execute still high means this is the strobe cycle itself.
                    if (!mem_execute && mem_ready) begin
                        wa        <= read_data1;
                        wb        <= read_data2;
                        root_mode <= (state == W_ROOT);
                        phase     <= 1'b0;
                        state     <= CMP;
                    end
                end
                CMP: begin
                    if (phase) begin
                        // Second half of a double push: head pair goes on top.
                        phase <= 1'b0;
                        if (stack_full) begin
                            state <= ERR;
                        end else begin
                            stk_a[push_idx] <= h_a;
                            stk_b[push_idx] <= h_b;
                            sp              <= sp + 1'b1;
                            state           <= RD_PAIR;
                        end
                    end else if (any_ne) begin
                        result <= 1'b1;
                        state  <= WR;
                    end else if (need_t || need_h) begin
                        if (stack_full) begin
                            state <= ERR;
                        end else begin
                            stk_a[push_idx] <= need_t ? t_a : h_a;
                            stk_b[push_idx] <= need_t ? t_b : h_b;
                            sp              <= sp + 1'b1;
                            if (need_t && need_h) phase <= 1'b1;
                            else                  state <= RD_PAIR;
                        end
                    end else if (sp == '0) begin
                        result <= 1'b0;
                        state  <= WR;
                    end else begin
                        state <= RD_PAIR;
                    end
                    if (state == CMP && !phase && !any_ne && (need_t || need_h) && stack_full) begin
                        state <= ERR;
                    end
                end
                RD_PAIR: begin
                    if (mem_ready) begin
                        address1    <= stk_a[top_idx];
                        address2    <= stk_b[top_idx];
                        sp          <= sp - 1'b1;
                        mem_func    <= 2'b00;
                        mem_execute <= 1'b1;
                        state       <= W_PAIR;
                    end
                end
                WR: begin
                    if (mem_ready) begin
                        address1    <= eq_address;
                        write_data  <= wr_word;
                        eq_data     <= wr_word;
                        mem_func    <= 2'b01;
                        mem_execute <= 1'b1;
                        state       <= W_WR;
                    end
                end
                W_WR: begin
                    if (!mem_execute && mem_ready) begin
                        finished           <= 1'b1;
                        eq_return_sys_func <= RET_SYS_FUNC;
                        eq_return_state    <= RET_STATE;
                        state              <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                ERR: begin
                    // Entered from CMP: report overflow once, no write-back.
                    if (eq_error == '0) begin
                        eq_error           <= TAG_W'(1);
                        finished           <= 1'b1;
                        eq_return_sys_func <= RET_SYS_FUNC;
                        eq_return_state    <= RET_STATE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_equal_block.sv
// Purpose: directed self-checking bench for equal_block with a behavioural memory.
// Latency: memory returns data the edge after the strobe; mem_lat adds busy cycles.
// Backpressure: mem_ready drops for mem_lat cycles after each request when mem_lat > 0.
module tb_equal_block;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    eq_start;
    logic [9:0]    module_address;
    logic [9:0]    eq_address;
    logic [DW-1:0] eq_data;
    logic          mem_ready;
    logic          mem_execute;
    logic [1:0]    mem_func;
    logic [9:0]    address1, address2;
    logic [9:0]    free_addr;
    logic [DW-1:0] read_data1, read_data2;
    logic [DW-1:0] write_data;
    logic          finished;
    logic [3:0]    eq_return_sys_func, eq_return_state;
    logic [3:0]    eq_error;

    always #5 clk = ~clk;

    equal_block dut (
        .clk(clk), .rst(rst), .eq_start(eq_start), .module_address(module_address),
        .eq_address(eq_address), .eq_data(eq_data), .mem_ready(mem_ready),
        .mem_execute(mem_execute), .mem_func(mem_func), .address1(address1),
        .address2(address2), .free_addr(free_addr), .read_data1(read_data1),
        .read_data2(read_data2), .write_data(write_data), .finished(finished),
        .eq_return_sys_func(eq_return_sys_func), .eq_return_state(eq_return_state),
        .eq_error(eq_error)
    );

    // Behavioural memory and bus monitors.
    logic [DW-1:0] mem [0:1023];
    int mem_lat = 0;
    int busy = 0;
    int rd_cnt = 0, wr_cnt = 0, fin_cnt = 0, proto_err = 0;
    logic exec_q = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mem_ready <= 1'b1;
            busy      <= 0;
            exec_q    <= 1'b0;
        end else begin
            exec_q <= mem_execute;
            if (mem_execute && (!mem_ready || exec_q)) proto_err <= proto_err + 1;
            if (finished) fin_cnt <= fin_cnt + 1;
            if (mem_execute) begin
                if (mem_func == 2'b01) begin
                    mem[address1] <= write_data;
                    wr_cnt <= wr_cnt + 1;
                end else begin
                    read_data1 <= mem[address1];
                    read_data2 <= mem[address2];
                    rd_cnt <= rd_cnt + 1;
                end
                if (mem_lat != 0) begin
                    mem_ready <= 1'b0;
                    busy      <= mem_lat;
                end
            end else if (busy != 0) begin
                busy <= busy - 1;
                if (busy == 1) mem_ready <= 1'b1;
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [DW-1:0] mk(input logic [3:0] t, input logic [9:0] h, input logic [9:0] l);
        return {t, h, l};
    endfunction

    localparam logic [DW-1:0] YES = 24'h000000;
    localparam logic [DW-1:0] NO  = 24'h000400;

    // Starts one operation on root cell 100 and waits (bounded) for finished.
    task automatic run(input string tag, output int lat);
        rd_cnt = 0; wr_cnt = 0; fin_cnt = 0;
        module_address = 10'd100;
        eq_start = 3'd4;
        @(posedge clk); #1;
        eq_start = 3'd2;   // select moving away mid-walk must not matter
        lat = 0;
        while (!finished && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_finished"}, finished, 1);
        repeat (2) begin @(posedge clk); #1; end
        chk({tag, "_fin_pulses"}, fin_cnt, 1);
        eq_start = 3'd0;
    endtask

    task automatic check_ok(input string tag, input logic [DW-1:0] exp, input int exp_rd);
        chk({tag, "_mem"}, mem[100], exp);
        chk({tag, "_eq_data"}, eq_data, exp);
        chk({tag, "_eq_addr"}, eq_address, 100);
        chk({tag, "_reads"}, rd_cnt, exp_rd);
        chk({tag, "_writes"}, wr_cnt, 1);
        chk({tag, "_err"}, eq_error, 0);
        chk({tag, "_ret"}, {eq_return_sys_func, eq_return_state}, 8'h10);
    endtask

    task automatic build_trees(input logic [9:0] deep_b);
        mem[300] = mk(4'h3, 10'd301, 10'd302);
        mem[301] = mk(4'h0, 10'd1, 10'd2);
        mem[302] = mk(4'h1, 10'd3, 10'd303);
        mem[303] = mk(4'h0, 10'd4, 10'd5);
        mem[400] = mk(4'h3, 10'd401, 10'd402);
        mem[401] = mk(4'h0, 10'd1, 10'd2);
        mem[402] = mk(4'h1, 10'd3, 10'd403);
        mem[403] = mk(4'h0, 10'd4, deep_b);
        mem[100] = mk(4'h3, 10'd300, 10'd400);
    endtask

    initial begin
        int lat;
        int guard;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rst = 1'b1;
        eq_start = 3'd4;     // start together with reset: reset must win
        module_address = 10'd100;
        free_addr = 10'd0;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_exec_fin", {mem_execute, finished}, 0);
        chk("rst_addrs", {eq_address, address1, address2}, 0);
        chk("rst_data", {eq_data, write_data}, 0);
        chk("rst_codes", {eq_return_sys_func, eq_return_state, eq_error, mem_func}, 0);
        rst = 1'b0;
        eq_start = 3'd0;
        @(posedge clk); #1;

        // Equal root atoms, 1-cycle memory: minimum latency.
        mem[100] = mk(4'h0, 10'd5, 10'd5);
        run("atoms_eq", lat);
        chk("atoms_eq_latency", lat, 7);
        check_ok("atoms_eq", YES, 1);

        mem[100] = mk(4'h0, 10'd5, 10'd6);
        run("atoms_ne", lat);
        check_ok("atoms_ne", NO, 1);

        mem[100] = mk(4'h1, 10'd5, 10'd200);
        run("atom_ptr", lat);
        check_ok("atom_ptr", NO, 1);

        build_trees(10'd5);
        run("trees_eq", lat);
        check_ok("trees_eq", YES, 5);

        build_trees(10'd7);
        run("trees_ne", lat);
        check_ok("trees_ne", NO, 5);

        mem[100] = mk(4'h3, 10'd300, 10'd300);
        run("same_ptr", lat);
        check_ok("same_ptr", YES, 1);

        // Two comb-shaped trees: every level pushes two pairs, so the stack grows until overflow.
        for (int i = 0; i < 18; i++) begin
            mem[500 + i] = mk(4'h3, 10'(501 + i), 10'(700 + i));
            mem[550 + i] = mk(4'h3, 10'(551 + i), 10'(750 + i));
            mem[700 + i] = mk(4'h0, 10'd9, 10'd9);
            mem[750 + i] = mk(4'h0, 10'd9, 10'd9);
        end
        mem[100] = mk(4'h3, 10'd500, 10'd550);
        run("overflow", lat);
        chk("overflow_err", eq_error, 1);
        chk("overflow_writes", wr_cnt, 0);
        chk("overflow_mem", mem[100], mk(4'h3, 10'd500, 10'd550));
        chk("overflow_reads", rd_cnt, 17);
        chk("overflow_ret", {eq_return_sys_func, eq_return_state}, 8'h10);

        // Slow memory, error flag must clear on the new start.
        mem_lat = 3;
        build_trees(10'd5);
        run("slow_eq", lat);
        check_ok("slow_eq", YES, 5);

        // Reset while waiting on a pair read.
        build_trees(10'd5);
        rd_cnt = 0; wr_cnt = 0; fin_cnt = 0;
        eq_start = 3'd4;
        @(posedge clk); #1;
        eq_start = 3'd0;
        guard = 0;
        while (!(mem_execute && mem_func == 2'b00 && address1 == 10'd300) && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("midrst_reached_pair", guard < 500, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_exec_fin", {mem_execute, finished}, 0);
        chk("midrst_addrs", {eq_address, address1, address2}, 0);
        chk("midrst_data", {eq_data, write_data, eq_error}, 0);
        repeat (20) begin @(posedge clk); #1; end
        chk("midrst_no_write", wr_cnt, 0);
        chk("midrst_no_fin", fin_cnt, 0);
        run("after_rst", lat);
        check_ok("after_rst", YES, 5);

        chk("protocol", proto_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/equal_block.md
# equal_block

Nock opcode 5 (equality) unit for the NockPU. Sits beside `execute`, `cell_block` and `incr_block` behind the memory mux and control mux. `mem_traversal` hands it a cell whose head and tail are two already-evaluated nouns. The block walks both nouns in lockstep with an explicit pair stack, writes the loobean result back in place, and returns control to the traversal unit.

## Interface
- SEL_ID, 3'd4: value of `eq_start` (mux select) that activates this block.
- ADDR_W, 10: memory address width; must equal `memory_addr_width`.
- VAL_W, 10: width of each head/tail field.
- TAG_W, 4: tag width; must equal `tag_width`.
- DATA_W, TAG_W+2*VAL_W: memory word width; must equal `memory_data_width`.
- STACK_DEPTH, 16: capacity of the internal address-pair stack.
- RET_SYS_FUNC, 4'd1: value driven on `eq_return_sys_func`.
- RET_STATE, 4'd0: value driven on `eq_return_state`.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- eq_start  in  3  mux select; the block starts when it equals SEL_ID while idle.
- eq_address  out  ADDR_W  address of the opcode cell being resolved.
- eq_data  out  DATA_W  result word written back.
- mem_ready  in  1  memory idle/complete.
- mem_execute  out  1  one-cycle memory request strobe.
- mem_func  out  2  2'b00 read, 2'b01 write.
- address1, address2  out  ADDR_W  memory addresses.
- free_addr  in  ADDR_W  unused; no allocation.
- read_data1, read_data2  in  DATA_W  memory read ports.
- write_data  out  DATA_W  memory write data.
- finished  out  1  one-cycle completion pulse.
- eq_return_sys_func, eq_return_state  out  4 each  return codes to the control mux.
- eq_error  out  TAG_W  0 ok, 4'h1 stack overflow.

## Operation
- Word layout: tag = [DATA_W-1 -: TAG_W], hed = next VAL_W bits, tail = low VAL_W bits.
- Tag bit1 = hed is a pointer. Tag bit0 = tail is a pointer. Other tag bits are ignored for comparison.
- States: IDLE → RD_ROOT → W_ROOT → CMP → RD_PAIR → W_PAIR → CMP … → WR → W_WR → DONE → IDLE. ERR is entered from CMP.
- IDLE: on `eq_start==SEL_ID`, latch `eq_address` from the traversal-supplied module address, clear the stack and `eq_error`, and move to RD_ROOT.
- RD_ROOT: read the root cell. Its hed and tail form the first pair (A, B).
  - If both are atoms, compare values.
  - If both are pointers and the addresses are equal, the pair is equal with no push.
  - If both are pointers and the addresses differ, push (A, B).
  - If one is an atom and the other a pointer, the result is "not equal".
- RD_PAIR: pop (a1, a2), drive `address1=a1` and `address2=a2`, and read both in one request.
- CMP compares the read words per field, hed first, then tail.
  - Field ptr-bit mismatch → not equal.
  - Both atoms with different values → not equal.
  - Both pointers with the same address → equal, no push.
  - Both pointers with different addresses → push.
- On "not equal", abandon the walk immediately, set result=1, and go to WR.
- When CMP completes with the stack empty, set result=0 and go to WR.
- Pushing a tail pair and a head pair in the same CMP takes two cycles. Push the tail pair first so the head pair is popped first.
- WR writes `{TAG_W'0, VAL_W'(result), VAL_W'0}` to `eq_address`. The same word is driven on `eq_data`.
- Overflow: a push with STACK_DEPTH entries present goes to ERR. ERR sets `eq_error=4'h1`, issues no write, and pulses `finished`.
- DONE: `finished` is high for 1 cycle. Return outputs hold RET_SYS_FUNC/RET_STATE from DONE/ERR until the next start.
- `eq_start` changing mid-walk is ignored; the walk completes.

## Timing
- Reset values: all outputs 0 (`mem_execute`, `finished`, addresses, data, return codes, `eq_error`). State is IDLE and the stack is empty.
- Memory handshake:
  - Issue a request only when `mem_ready==1`.
  - Assert `mem_execute` for exactly one cycle with func, address and data stable that cycle.
  - Then wait in a W_* state until `mem_ready` reads 1 on a cycle at least one cycle after the strobe.
  - Sample `read_data*` in that cycle.
- Minimum latency for equal atoms at the root: start → `finished` = 7 cycles with a 1-cycle memory.
- Each popped pair adds about 3 cycles plus memory wait, and 1 extra cycle when two pairs are pushed.
- Reset asserted mid-operation: the block returns to IDLE on the next edge. Any in-flight `mem_execute` drops immediately, with no write and no `finished`.
- Start and reset in the same cycle: reset wins.

## Test plan
- Root [5 5] (both atoms) → `write_data` hed=0 at `eq_address`, `finished` 1 cycle, `eq_error`=0.
- Root [5 6] → hed=1. Root [5 ptr] → hed=1 with no pair read issued.
- Two distinct trees [[1 2] [3 [4 5]]] at different addresses → hed=0. Differ only in the deepest atom (5 vs 7) → hed=1 after reading the mismatching pair.
- Root whose hed and tail point to the same address → hed=0 with zero RD_PAIR requests.
- Degenerate tree of depth STACK_DEPTH+2 on both sides → ERR, `eq_error`=4'h1, no write, `finished` pulses.
- Assert `rst` for one cycle during W_PAIR → all outputs 0 next cycle. A new start then yields the correct result.
